// File: rtl/io_rx_frontend.sv
// Byte-stream front end for the SRAM image-write controller: parses a two-byte
// header (nrows, ncols), prefills a pixel FIFO, then streams one pixel per cycle.
module io_rx_frontend #(
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       rx_busy,
    output logic [7:0] nrows,
    output logic [7:0] ncols,
    output logic       en,
    output logic [7:0] din,
    output logic       active,
    output logic       done,
    output logic       underrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [16:0]   PREFILL_W = 17'(PREFILL);
    localparam logic [CW-1:0] DEPTH_W   = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        HDR_ROWS,
        HDR_COLS,
        FILL,
        LAUNCH,
        STREAM,
        DRAIN
    } state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [16:0]   n_total;
    logic [16:0]   pixels_received;
    logic [16:0]   pixels_sent;

    logic          streaming;
    logic          fifo_empty;
    logic          pop;
    logic          push;
    logic [16:0]   threshold;
    logic          launch_ok;

    always_comb begin
        streaming  = (state == LAUNCH) || (state == STREAM);
        fifo_empty = (count == '0);
        pop        = streaming && !fifo_empty;

        case (state)
            HDR_ROWS, HDR_COLS:   in_ready = 1'b1;
            FILL, LAUNCH, STREAM: in_ready = (count < DEPTH_W) && (pixels_received < n_total);
            default:              in_ready = 1'b0;
        endcase

        push = in_valid && in_ready && ((state == FILL) || streaming);
        en   = (state == LAUNCH);
        din  = pop ? mem[rd_ptr] : 8'h00;

        // Tiny images launch as soon as the whole frame is buffered.
        threshold = (n_total < PREFILL_W) ? n_total : PREFILL_W;
        launch_ok = (17'(count) >= threshold) && !rx_busy;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= HDR_ROWS;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            n_total         <= '0;
            pixels_received <= '0;
            pixels_sent     <= '0;
            nrows           <= '0;
            ncols           <= '0;
            active          <= 1'b0;
            done            <= 1'b0;
            underrun        <= 1'b0;
        end else begin
            done <= 1'b0;

            if (push) begin
                wr_ptr          <= wr_ptr + AW'(1);
                pixels_received <= pixels_received + 17'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end

            // A due pixel with nothing buffered still counts as sent (din reads 0).
            if (streaming && fifo_empty) begin
                underrun <= 1'b1;
            end

            case (state)
                HDR_ROWS: begin
                    if (in_valid) begin
                        nrows    <= in_data;
                        underrun <= 1'b0;
                        active   <= 1'b1;
                        state    <= HDR_COLS;
                    end
                end
                HDR_COLS: begin
                    if (in_valid) begin
                        ncols           <= in_data;
                        n_total         <= (17'(nrows) + 17'd1) * (17'(in_data) + 17'd1);
                        pixels_received <= '0;
                        pixels_sent     <= '0;
                        state           <= FILL;
                    end
                end
                FILL: begin
                    if (launch_ok) begin
                        state <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    pixels_sent <= 17'd1;
                    state       <= (n_total == 17'd1) ? DRAIN : STREAM;
                end
                STREAM: begin
                    pixels_sent <= pixels_sent + 17'd1;
                    if (pixels_sent + 17'd1 == n_total) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leftover bytes from an underrun frame are flushed here.
                    if (!rx_busy) begin
                        done   <= 1'b1;
                        active <= 1'b0;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                        state  <= HDR_ROWS;
                    end
                end
                default: state <= HDR_ROWS;
            endcase
        end
    end

endmodule

// File: tb/tb_io_rx_frontend.sv
// Scoreboard bench for io_rx_frontend: a cycle model predicts en/done/in_ready
// and a byte queue holds accepted pixels until the DUT is due to emit them.
module tb_io_rx_frontend;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       rx_busy = 1'b0;
    logic [7:0] nrows;
    logic [7:0] ncols;
    logic       en;
    logic [7:0] din;
    logic       active;
    logic       done;
    logic       underrun;

    int total = 0;
    int bad   = 0;

    io_rx_frontend #(.FIFO_DEPTH(16), .PREFILL(8)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rx_busy  (rx_busy),
        .nrows    (nrows),
        .ncols    (ncols),
        .en       (en),
        .din      (din),
        .active   (active),
        .done     (done),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Model state
    bit         mon_on = 1'b0;
    int         phase, rows_m, cols_m, n_m, recv_m, out_left, thr;
    logic [7:0] q[$];
    bit         filling, in_drain, nx_drain;
    bit         exp_en, exp_done, exp_active, exp_underrun;
    int         exp_ready_m;
    logic [7:0] exp_din_m;
    int         busy_left = 0;
    bit         busy_hold = 1'b0;
    bit         src_abort = 1'b0;
    bit         src_active = 1'b0;
    int         cyc = 0;
    int         en_cnt, done_cnt, zero_cnt, pix_out, done_cyc, hdr_gap;
    logic [7:0] src_q[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic resetModel();
        phase = 0; rows_m = 0; cols_m = 0; n_m = 0; recv_m = 0; out_left = 0;
        q.delete();
        filling = 0; in_drain = 0; exp_en = 0; exp_done = 0;
        exp_active = 0; exp_underrun = 0; busy_left = 0; busy_hold = 0;
        en_cnt = 0; zero_cnt = 0; pix_out = 0;
    endtask

    // Downstream write controller: busy for a while after each launch.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (busy_left > 0) busy_left--;
            rx_busy = busy_hold || (busy_left > 0);
        end
    end

    // Monitor: checks the current cycle, then advances the model.
    always @(negedge clk) begin
        if (mon_on) begin
            cyc++;
            checkOutput("en", en, exp_en);
            checkOutput("done", done, exp_done);
            checkOutput("active", active, exp_active);
            checkOutput("underrun", underrun, exp_underrun);
            checkOutput("nrows", nrows, rows_m);
            checkOutput("ncols", ncols, cols_m);
            if (phase < 2)      exp_ready_m = 1;
            else if (in_drain)  exp_ready_m = 0;
            else                exp_ready_m = (q.size() < 16 && recv_m < n_m) ? 1 : 0;
            checkOutput("in_ready", in_ready, exp_ready_m);
            if (en) en_cnt++;
            if (done) begin done_cnt++; done_cyc = cyc; end

            if (exp_en) begin
                out_left  = n_m;
                busy_left = n_m + 2;
            end
            nx_drain = 0;
            if (out_left > 0) begin
                if (q.size() > 0) begin
                    exp_din_m = q.pop_front();
                end else begin
                    exp_din_m    = 8'h00;
                    exp_underrun = 1;
                    zero_cnt++;
                end
                checkOutput("din", din, exp_din_m);
                pix_out++;
                out_left--;
                if (out_left == 0) nx_drain = 1;
            end else begin
                checkOutput("din_idle", din, 0);
            end

            thr    = (n_m < 8) ? n_m : 8;
            exp_en = filling && (q.size() >= thr) && !rx_busy;
            if (exp_en) filling = 0;
            exp_done = in_drain && !rx_busy;
            if (exp_done) begin
                in_drain   = 0;
                phase      = 0;
                exp_active = 0;
                src_abort  = 1;
                q.delete();
            end
            if (nx_drain) in_drain = 1;

            if (in_valid && in_ready) begin
                case (phase)
                    0: begin
                        rows_m = in_data; exp_underrun = 0; exp_active = 1; phase = 1;
                        hdr_gap = cyc - done_cyc; en_cnt = 0; zero_cnt = 0; pix_out = 0;
                    end
                    1: begin
                        cols_m = in_data; n_m = (rows_m + 1) * (cols_m + 1);
                        recv_m = 0; filling = 1; phase = 2;
                    end
                    default: begin
                        q.push_back(in_data);
                        recv_m++;
                    end
                endcase
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input bit abortable, output bit aborted);
        int guard;
        bit sent;
        aborted = 0; sent = 0; guard = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!sent && !aborted && guard < 3000) begin
            #3;
            if (abortable && src_abort) begin
                in_valid = 1'b0;
                aborted  = 1;
            end else begin
                if (in_ready) sent = 1; else guard++;
                @(posedge clk);
                #1;
            end
        end
        if (!sent && !aborted) begin
            checkOutput("src_timeout", sent, 1);
            in_valid = 1'b0;
            aborted  = 1;
        end
    endtask

    task automatic applyStimulus(input int stall_at, input int stall_len, input bit abortable);
        bit ab;
        ab = 0;
        src_active = 1;
        src_abort  = 0;
        for (int i = 0; i < src_q.size() && !ab; i++) begin
            if (i == stall_at) begin
                in_valid = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            sendByte(src_q[i], abortable, ab);
        end
        in_valid   = 1'b0;
        src_active = 0;
    endtask

    task automatic waitDone(input int target, input string tag);
        int g;
        g = 0;
        while (done_cnt < target && g < 5000) begin
            @(posedge clk);
            g++;
        end
        checkOutput(tag, done_cnt, target);
        @(posedge clk);
        #1;
    endtask

    task automatic waitSrc();
        int g;
        g = 0;
        while (src_active && g < 5000) begin
            @(posedge clk);
            g++;
        end
        checkOutput("src_finished", src_active, 0);
        #1;
    endtask

    task automatic loadFrame(input logic [7:0] r, input logic [7:0] c, input int npix, input logic [7:0] base);
        src_q.delete();
        src_q.push_back(r);
        src_q.push_back(c);
        for (int i = 0; i < npix; i++) src_q.push_back(base + 8'(i));
    endtask

    initial begin
        int start;
        rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        done_cnt = 0; done_cyc = 0; hdr_gap = 0;
        resetModel();
        #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_en", en, 0);
        checkOutput("rst_din", din, 0);
        checkOutput("rst_nrows", nrows, 0);
        checkOutput("rst_ncols", ncols, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_underrun", underrun, 0);
        checkOutput("rst_active", active, 0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        mon_on = 1'b1;

        // Basic 2x3 frame
        src_q = '{8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        start = done_cnt;
        applyStimulus(-1, 0, 0);
        waitDone(start + 1, "basic_done");
        checkOutput("basic_en_count", en_cnt, 1);
        checkOutput("basic_pixels", pix_out, 6);
        checkOutput("basic_nrows", nrows, 1);
        checkOutput("basic_ncols", ncols, 2);
        checkOutput("basic_underrun", underrun, 0);

        // Single pixel
        src_q = '{8'h00, 8'h00, 8'hAA};
        start = done_cnt;
        applyStimulus(-1, 0, 0);
        waitDone(start + 1, "single_done");
        checkOutput("single_en_count", en_cnt, 1);
        checkOutput("single_pixels", pix_out, 1);

        // Backpressure: downstream busy while the FIFO fills
        busy_hold = 1;
        loadFrame(8'h03, 8'h07, 32, 8'h40);
        start = done_cnt;
        fork
            applyStimulus(-1, 0, 0);
        join_none
        repeat (40) @(posedge clk);
        #1;
        checkOutput("bp_ready_full", in_ready, 0);
        checkOutput("bp_no_launch", en_cnt, 0);
        busy_hold = 0;
        waitSrc();
        waitDone(start + 1, "bp_done");
        checkOutput("bp_pixels", pix_out, 32);
        checkOutput("bp_underrun", underrun, 0);

        // Underrun: source pauses after 10 pixels long enough to drain the FIFO
        loadFrame(8'h03, 8'h07, 32, 8'h80);
        start = done_cnt;
        applyStimulus(12, 11, 1);
        waitDone(start + 1, "ur_done");
        checkOutput("ur_zero_cycles", zero_cnt, 3);
        checkOutput("ur_pixels", pix_out, 32);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("ur_sticky", underrun, 1);

        // Reset in the middle of streaming
        loadFrame(8'h03, 8'h07, 32, 8'hC0);
        pix_out = 0;
        fork
            applyStimulus(-1, 0, 1);
            begin
                int g;
                g = 0;
                while (pix_out < 5 && g < 2000) begin
                    @(posedge clk);
                    g++;
                end
                #1;
                mon_on    = 0;
                rstn      = 1'b0;
                src_abort = 1;
                #2;
                checkOutput("mid_rst_en", en, 0);
                checkOutput("mid_rst_din", din, 0);
                checkOutput("mid_rst_active", active, 0);
                checkOutput("mid_rst_underrun", underrun, 0);
                checkOutput("mid_rst_in_ready", in_ready, 1);
                checkOutput("mid_rst_nrows", nrows, 0);
            end
        join
        @(posedge clk);
        #1;
        resetModel();
        rstn   = 1'b1;
        mon_on = 1'b1;
        src_q = '{8'h00, 8'h01, 8'h55, 8'h66};
        start = done_cnt;
        applyStimulus(-1, 0, 0);
        waitDone(start + 1, "post_rst_done");
        checkOutput("post_rst_pixels", pix_out, 2);

        // Back-to-back frames with no idle gap
        src_q = '{8'h01, 8'h01, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h02, 8'hB1, 8'hB2, 8'hB3};
        start = done_cnt;
        applyStimulus(-1, 0, 0);
        waitDone(start + 2, "b2b_done");
        checkOutput("b2b_hdr_in_done_cycle", hdr_gap, 0);
        checkOutput("b2b_nrows", nrows, 0);
        checkOutput("b2b_ncols", ncols, 2);
        checkOutput("b2b_en_count", en_cnt, 1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
